// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_ctrl_pkg: states, opcodes and select encodings shared by the
// multi-cycle controller, ALU_Control and the datapath.   Rev 1.0
// ----------------------------------------------------------------------------
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_TRAP      = 4'd9
  } state_e;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_SD    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mc_ctrl_outputs.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_ctrl_outputs: combinational state-to-control decode with reset gating.
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_ctrl_outputs
  import riscv_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic       rst_n_i,
  input  logic       mem_ready_i,
  input  logic       zero_i,
  output logic       pc_en_o,
  output logic       pc_src_o,
  output logic       ir_write_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic       mem_to_reg_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_o
);

  logic pc_write;
  logic pc_write_cond;

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_en_o       = 1'b0;
    pc_src_o      = 1'b0;
    ir_write_o    = 1'b0;
    i_or_d_o      = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    reg_write_o   = 1'b0;
    mem_to_reg_o  = 1'b0;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRCB_RS2;
    alu_op_o      = ALUOP_ADD;
    illegal_o     = 1'b0;

    case (state_i)
      ST_FETCH: begin
        // Request is held regardless of mem_ready; only the loads wait on it.
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write    = mem_ready_i;
      end
      ST_DECODE:   alu_src_b_o = SRCB_IMM;
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      ST_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALUOP_FUNCT;
      end
      ST_R_WB:     reg_write_o = 1'b1;
      ST_BRANCH: begin
        alu_src_a_o   = 1'b1;
        alu_op_o      = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src_o      = 1'b1;
      end
      ST_TRAP:     illegal_o = 1'b1;
      default:     ;
    endcase

    pc_en_o = pc_write | (pc_write_cond & zero_i);

    // While in reset no enable or request may reach the datapath or memory.
    if (!rst_n_i) begin
      pc_en_o     = 1'b0;
      ir_write_o  = 1'b0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      reg_write_o = 1'b0;
      illegal_o   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ----------------------------------------------------------------------------
// multicycle_control: FSM sequencing the multi-cycle RV64 datapath, with a
// retired-instruction counter.   Rev 1.0
// ----------------------------------------------------------------------------
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             pc_src,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic             store_q, store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_LD, OP_SD: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEM_ADDR: state_d = store_q ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ: if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_MEM_WRITE: begin
        if (mem_ready) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_R_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_BRANCH: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP:     state_d = ST_FETCH;
      default:     state_d = ST_FETCH;
    endcase
  end

  // The load/store class is captured in DECODE; the IR may be reused later.
  assign store_d = (state_q == ST_DECODE) ? (opcode == OP_SD) : store_q;
  assign cnt_d   = retire ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      store_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_count = cnt_q;

  mc_ctrl_outputs u_outputs (
    .state_i      (state_q),
    .rst_n_i      (reset),
    .mem_ready_i  (mem_ready),
    .zero_i       (zero),
    .pc_en_o      (pc_en),
    .pc_src_o     (pc_src),
    .ir_write_o   (ir_write),
    .i_or_d_o     (i_or_d),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .reg_write_o  (reg_write),
    .mem_to_reg_o (mem_to_reg),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .illegal_o    (illegal)
  );

endmodule
`default_nettype wire
